// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, issues one request at a
//               time to instruction memory over a req/rvalid handshake, and
//               drives the IF/ID pipeline register consumed by decode.
//               Honours the hazard-unit stall and the decode-stage redirect
//               (flush plus discard of the in-flight fetch).
//               Optional macro IF_PERF_CNT_EN adds fetch/stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter int                  WORD_LEN  = 16,
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WORD_LEN-1:0] NOP_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected,
  input  logic                brTaken,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count,
  output logic [31:0]         flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [WORD_LEN-1:0] buf_q, buf_d;
  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pcid_q, pcid_d;

  logic                deliver;
  logic [WORD_LEN-1:0] deliver_word;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign imem_req    = (state_q == ST_ISSUE) & rst;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_ID       = pcid_q;

  // Fetch sequencing: next state, PC, kill flag, hold buffer and IF/ID contents
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_word = buf_q;

    case (state_q)
      ST_ISSUE: begin
        state_d = ST_WAIT;
        // The request just issued targets the old PC, so its data must die.
        if (brTaken) begin
          pc_d   = br_target;
          kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_ISSUE;
          if (kill_q) begin
            // The killed response is now consumed; nothing else is in flight.
            kill_d = 1'b0;
            if (brTaken) pc_d = br_target;
          end else if (brTaken) begin
            pc_d = br_target;
          end else if (hazard_detected) begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
          end
        end else if (brTaken) begin
          pc_d   = br_target;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (brTaken) begin
          pc_d    = br_target;
          state_d = ST_ISSUE;
        end else if (!hazard_detected) begin
          deliver      = 1'b1;
          deliver_word = buf_q;
          state_d      = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase

    if (deliver) pc_d = pc_inc;

    instr_d = instr_q;
    valid_d = valid_q;
    pcid_d  = pcid_q;
    if (brTaken) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (deliver) begin
      instr_d = deliver_word;
      valid_d = 1'b1;
      pcid_d  = pc_inc;
    end else if (!hazard_detected) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      buf_q   <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      pcid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pcid_q  <= pcid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (deliver)         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (hazard_detected) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (brTaken)         flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed scenarios followed
//               by randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        hazard_detected;
  logic        brTaken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc_ID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, flush_count;
  logic [31:0] md_fetch, md_stall, md_flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder state: one outstanding request, programmable latency.
  bit          mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr;
  int          mem_delay;
  bit          mem_rand;

  // Reference model: fetch address, whether a request is in flight, whether
  // its data has been orphaned by a redirect, and a queue of fetched-but-stalled words.
  logic [15:0] md_pc, md_instr, md_pcid;
  bit          md_busy, md_kill, md_valid;
  logic [15:0] md_held[$];

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_detected(hazard_detected),
    .brTaken        (brTaken),
    .br_target      (br_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pc_ID          (pc_ID)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input bit r, input bit h, input bit b,
                              input logic [15:0] t, input bit rv, input logic [15:0] rd);
    bit          deliver;
    logic [15:0] dword;
    deliver = 0;
    dword   = '0;
    if (!r) begin
      md_pc = 16'h0000; md_busy = 0; md_kill = 0; md_held.delete();
      md_instr = 16'h0000; md_valid = 0; md_pcid = 16'h0000;
`ifdef IF_PERF_CNT_EN
      md_fetch = 0; md_stall = 0; md_flush = 0;
`endif
      return;
    end
    if (!md_busy && md_held.size() == 0) begin
      md_busy = 1;
      if (b) begin md_pc = t; md_kill = 1; end
    end else if (md_busy) begin
      if (rv) begin
        md_busy = 0;
        if (md_kill) begin
          md_kill = 0;
          if (b) md_pc = t;
        end else if (b) md_pc = t;
        else if (h) md_held.push_back(rd);
        else begin deliver = 1; dword = rd; end
      end else if (b) begin
        md_pc = t; md_kill = 1;
      end
    end else begin
      if (b) begin md_held.delete(); md_pc = t; end
      else if (!h) begin deliver = 1; dword = md_held.pop_front(); end
    end
    if (b) begin
      md_instr = 16'h0000; md_valid = 0;
    end else if (deliver) begin
      md_instr = dword; md_valid = 1; md_pcid = md_pc + 16'd1; md_pc = md_pc + 16'd1;
    end else if (!h) begin
      md_instr = 16'h0000; md_valid = 0;
    end
`ifdef IF_PERF_CNT_EN
    if (deliver) md_fetch++;
    if (h) md_stall++;
    if (b) md_flush++;
`endif
  endtask

  // Drive one cycle of inputs, advance model and memory, return at posedge+1.
  task automatic step(input bit r, input bit h, input bit b, input logic [15:0] t);
    logic        req_s;
    logic [15:0] addr_s;
    rst             = r;
    hazard_detected = h;
    brTaken         = b;
    br_target       = t;
    imem_rvalid     = mem_pend && (mem_cnt == 0);
    imem_rdata      = imem_rvalid ? 16'(mem_addr + 16'h1000) : 16'($urandom);
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    model_update(r, h, b, t, imem_rvalid, imem_rdata);
    @(posedge clk);
    #1;
    if (!r) mem_pend = 0;
    else if (req_s === 1'b1) begin
      mem_pend = 1;
      mem_addr = addr_s;
      mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
    end else if (mem_pend) begin
      if (mem_cnt == 0) mem_pend = 0;
      else mem_cnt--;
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      n_errors++; $display("FAIL reset_req: got req=%b addr=%h expected req=0 addr=0000", imem_req, imem_addr);
    end
    n_checks++;
    if (instruction !== 16'h0000 || instr_valid !== 1'b0 || pc_ID !== 16'h0000) begin
      n_errors++; $display("FAIL reset_ifid: got instr=%h valid=%b pc_ID=%h expected 0000/0/0000", instruction, instr_valid, pc_ID);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_errors++; $display("FAIL reset_release_req: got %b expected 1", imem_req);
    end
  endtask

  task automatic test_sequential();
    mem_delay = 0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i % 2 == 0) begin
        if (imem_req !== 1'b1 || imem_addr !== 16'(i / 2)) begin
          n_errors++; $display("FAIL seq_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 16'(i / 2));
        end
      end else if (imem_req !== 1'b0) begin
        n_errors++; $display("FAIL seq_idle[%0d]: got req=%b expected 0", i, imem_req);
      end
      step(1, 0, 0, 16'h0);
      n_checks++;
      if (i % 2 == 1) begin
        if (instruction !== 16'h1000 + 16'(i / 2) || instr_valid !== 1'b1 || pc_ID !== 16'(i / 2 + 1)) begin
          n_errors++; $display("FAIL seq_ifid[%0d]: got %h/%b/%h expected %h/1/%h", i, instruction, instr_valid, pc_ID,
                               16'h1000 + 16'(i / 2), 16'(i / 2 + 1));
        end
      end else if (instr_valid !== 1'b0) begin
        n_errors++; $display("FAIL seq_bubble[%0d]: got valid=%b expected 0", i, instr_valid);
      end
    end
  endtask

  task automatic test_delayed();
    mem_delay = 3;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin
      n_errors++; $display("FAIL dly_req: got req=%b addr=%h expected 1/0003", imem_req, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_errors++; $display("FAIL dly_wait_req[%0d]: got %b expected 0", i, imem_req);
        end
      end
      step(1, 0, 0, 16'h0);
      n_checks++;
      if (i < 4 && instr_valid !== 1'b0) begin
        n_errors++; $display("FAIL dly_bubble[%0d]: got valid=%b expected 0", i, instr_valid);
      end else if (i == 4 && (instruction !== 16'h1003 || instr_valid !== 1'b1 || pc_ID !== 16'h0004)) begin
        n_errors++; $display("FAIL dly_load: got %h/%b/%h expected 1003/1/0004", instruction, instr_valid, pc_ID);
      end
    end
  endtask

  task automatic test_hazard();
    mem_delay = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_errors++; $display("FAIL haz_req[%0d]: got %b expected 0", i, imem_req);
        end
      end
      step(1, i < 4, 0, 16'h0);
      n_checks++;
      if (i < 4 && (instruction !== 16'h1003 || instr_valid !== 1'b1 || pc_ID !== 16'h0004)) begin
        n_errors++; $display("FAIL haz_hold[%0d]: got %h/%b/%h expected 1003/1/0004", i, instruction, instr_valid, pc_ID);
      end else if (i == 4 && (instruction !== 16'h1004 || instr_valid !== 1'b1 || pc_ID !== 16'h0005)) begin
        n_errors++; $display("FAIL haz_release: got %h/%b/%h expected 1004/1/0005", instruction, instr_valid, pc_ID);
      end
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin
      n_errors++; $display("FAIL haz_next_fetch: got req=%b addr=%h expected 1/0005", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_wait();
    mem_delay = 2;
    step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0040);
    n_checks++;
    if (instruction !== 16'h0000 || instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL brw_flush: got %h/%b expected 0000/0", instruction, instr_valid);
    end
    mem_delay = 0;
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_errors++; $display("FAIL brw_redirect: got valid=%b req=%b addr=%h expected 0/1/0040", instr_valid, imem_req, imem_addr);
    end
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (instruction !== 16'h1040 || instr_valid !== 1'b1 || pc_ID !== 16'h0041) begin
      n_errors++; $display("FAIL brw_target_load: got %h/%b/%h expected 1040/1/0041", instruction, instr_valid, pc_ID);
    end
  endtask

  task automatic test_branch_hold();
    mem_delay = 0;
    step(1, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    step(1, 1, 1, 16'h0080);
    n_checks++;
    if (instruction !== 16'h0000 || instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL brh_flush: got %h/%b expected 0000/0", instruction, instr_valid);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      n_errors++; $display("FAIL brh_redirect: got req=%b addr=%h expected 1/0080", imem_req, imem_addr);
    end
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (instruction !== 16'h1080 || instr_valid !== 1'b1 || pc_ID !== 16'h0081) begin
      n_errors++; $display("FAIL brh_target_load: got %h/%b/%h expected 1080/1/0081", instruction, instr_valid, pc_ID);
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
      n_errors++; $display("FAIL wrap_req: got req=%b addr=%h expected 1/ffff", imem_req, imem_addr);
    end
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (instruction !== 16'h0FFF || instr_valid !== 1'b1 || pc_ID !== 16'h0000) begin
      n_errors++; $display("FAIL wrap_ifid: got %h/%b/%h expected 0fff/1/0000", instruction, instr_valid, pc_ID);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    mem_delay = 3;
    step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0100);
    step(1, 0, 1, 16'h0200);
    mem_delay = 0;
    k = 0;
    while (imem_req !== 1'b1 && k < 10) begin
      step(1, 0, 0, 16'h0);
      k++;
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_redirect: got req=%b addr=%h valid=%b after %0d cycles expected 1/0200/0",
                           imem_req, imem_addr, instr_valid, k);
    end
  endtask

  task automatic test_random();
    bit exp_req;
    mem_rand = 1;
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 64) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 16'($urandom));
      exp_req = rst && !md_busy && (md_held.size() == 0);
      n_checks++;
      if (imem_req !== exp_req || imem_addr !== md_pc) begin
        n_errors++; $display("FAIL rnd_fetch[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, exp_req, md_pc);
      end
      n_checks++;
      if (instruction !== md_instr || instr_valid !== md_valid || pc_ID !== md_pcid) begin
        n_errors++; $display("FAIL rnd_ifid[%0d]: got %h/%b/%h expected %h/%b/%h", i, instruction, instr_valid, pc_ID,
                             md_instr, md_valid, md_pcid);
      end
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (instruction !== 16'(pc_ID - 16'd1 + 16'h1000)) begin
          n_errors++; $display("FAIL rnd_word_addr[%0d]: got %h expected %h", i, instruction, 16'(pc_ID - 16'd1 + 16'h1000));
        end
      end
    end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (fetch_count !== md_fetch || stall_count !== md_stall || flush_count !== md_flush) begin
      n_errors++; $display("FAIL perf_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", fetch_count, stall_count, flush_count,
                           md_fetch, md_stall, md_flush);
    end
`endif
  endtask

  initial begin
    rst = 1'b0; hazard_detected = 1'b0; brTaken = 1'b0; br_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    mem_pend = 0; mem_cnt = 0; mem_addr = '0; mem_delay = 0; mem_rand = 0;
    test_reset();
    test_sequential();
    test_delayed();
    test_hazard();
    test_branch_wait();
    test_branch_hold();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
